pic_inta_sequencer: RTL
=======================

# pic_inta_sequencer

Clocked acknowledge sequencer for the 8-level interrupt controller. It owns the interrupt request register (IRR) and in-service register (ISR), resolves priority among unmasked requests, and drives `int_out`. It then runs the two-pulse INTA handshake with the CPU, placing the vector on the data bus buffer during the second pulse. It sits between the request lines and mask register on one side and the data bus buffer and CPU on the other.

## Interface
- `NUM_IR`, 8: request lines. Fixed at 8; a 3-bit level ID follows from it.
- `clk` in 1: system clock, all state updates on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `ir` in 8: level-sensitive request lines, synchronous to `clk`.
- `imr` in 8: mask, 1 = level masked.
- `vector_base` in 5: vector bits T7..T3.
- `eoi` in 1: one-cycle pulse, non-specific end-of-interrupt.
- `inta_n` in 1: CPU acknowledge, active-low, synchronous to `clk`.
- `int_out` out 1: interrupt request to CPU.
- `data_out` out 8: vector to data bus buffer.
- `data_oe` out 1: 1 = buffer drives `data_out` (read direction).
- `irr` out 8: current IRR.
- `isr` out 8: current ISR.

## Operation
- **Reset:** while `reset_n`=0 at an edge, all of the following clear:
  - `irr`, `isr`, `data_out`, `int_out`, `data_oe` = 0.
  - State = IDLE, `inta_q` = 1.
  - Lowest-priority pointer = 7, so IR0 is highest priority.
  - Reset in any state aborts the handshake.
- **IRR capture:** each edge, `irr[i]` takes `ir[i]`, except the bit being acknowledged, which is forced 0 on the first INTA.
- **Candidate:** the highest-priority set bit of `irr & ~imr`, scanned from (pointer+1) mod 8 upward.
- **Request condition:** a candidate exists and its priority is strictly higher than every set `isr` bit (fully nested). Equal or lower priority is blocked.
- **INTA edge detect:** fall = `inta_q`=1 and `inta_n`=0; rise = `inta_q`=0 and `inta_n`=1. `inta_q` registers `inta_n`.
- **States:**
  - IDLE: when the request condition holds, go to REQ and set `int_out`=1.
  - REQ: on fall, latch `ack_id`, set `isr[ack_id]`, clear `irr[ack_id]`, set `int_out`=0, go to ACK1. If the request condition is false at the fall, `ack_id`=7 (spurious) and no ISR bit is set.
  - ACK1: on rise, go to GAP.
  - GAP: on fall, set `data_out` = {`vector_base`, `ack_id`}, `data_oe`=1, go to ACK2.
  - ACK2: on rise, set `data_oe`=0, `data_out`=0, go to IDLE.
- A request withdrawn in REQ before any INTA drops `int_out` and returns to IDLE.
- **EOI:** clears the highest-priority set `isr` bit. With EOI and no ISR bit set, nothing changes.
  - EOI coincident with the first-INTA ISR set: EOI evaluates the pre-edge `isr`, then the new bit is ORed in.
- Masking a level does not affect its `isr` bit.

## Timing
- `ir` rises and is sampled at edge k. `irr` updates at k, and `int_out` goes high after edge k+1 (one-cycle latency).
- First `inta_n` low sampled at edge m: `isr`/`irr` update and `int_out` falls after m.
- Second `inta_n` low sampled at edge p: `data_oe`=1 from after p until after the edge that samples `inta_n` high.
- The minimum INTA low or high phase is 1 clk. No timeout: the FSM waits indefinitely in REQ/ACK1/GAP/ACK2.
- An `eoi` pulse takes effect at the edge that samples it.

## Configuration
- `PIC_ROTATE_PRIORITY_EN` defined: on EOI, the pointer loads the cleared level, so that level becomes lowest priority.
- Not defined: the pointer is constant 7 (fixed priority, IR0 highest) and its register is removed.

## Structure
- Package `pic_pkg`:
  - `NUM_IR` = 8, `ID_W` = 3, `SPURIOUS_ID` = 3'd7.
  - State enum `pic_ack_state_t` (IDLE, REQ, ACK1, GAP, ACK2).
- One sub-module, `pic_priority_resolver`: combinational, inputs request vector and pointer, outputs `valid` and a 3-bit ID. It is used for both candidate selection and the EOI target (applied to `isr`).

## Test plan
- **Single request:** `ir`=8'h08, `imr`=0, `vector_base`=5'h11 → `int_out` high 2 edges later. Two INTA pulses → `isr`=8'h08, `irr[3]`=0, `data_out`=8'h8B during the second pulse, `data_oe` 0 after it.
- **Priority and mask:** `ir`=8'h24, `imr`=8'h04 → vector ID 5. Then `imr`=0 with `isr`=8'h20 → IR2 nests and `int_out` rises.
- **Nesting block:** `isr`=8'h02 and `ir`=8'h10 → `int_out` stays 0. After `eoi`, `isr`=0 and `int_out` rises.
- **Spurious:** `ir[4]` drops between `int_out` and the first INTA → ID 7 and `isr` unchanged.
- **Rotation (macro on):** service IR1 then `eoi`. With `ir`=8'h03, IR0 is still served first. Requests from IR2 outrank IR0 → with `ir`=8'h05, ID 2 is served.
- **Reset mid-handshake:** `reset_n`=0 in GAP → after the edge, all outputs 0, state IDLE. `ir` held high → `int_out` reasserts after 2 edges.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the 8-level interrupt controller acknowledge path.
//   NUM_IR      : number of request levels (fixed at 8)
//   ID_W        : width of a level ID
//   SPURIOUS_ID : ID returned when the request vanishes before the first INTA
//   RESET_PTR   : lowest-priority pointer after reset (IR0 highest)
//   pic_ack_state_t : acknowledge handshake states
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned ID_W   = 3;

  localparam logic [ID_W-1:0] SPURIOUS_ID = 3'd7;
  localparam logic [ID_W-1:0] RESET_PTR   = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAck1,
    StGap,
    StAck2
  } pic_ack_state_t;

  // Rank 0 is the highest priority: the level just above the lowest-priority pointer.
  function automatic logic [ID_W-1:0] prio_rank(logic [ID_W-1:0] id, logic [ID_W-1:0] ptr);
    return id - ptr - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority resolver. Finds the highest-priority set bit of req_i, scanning upward
// from level (ptr_i + 1) mod 8 and wrapping.
//   req_i   : request vector, one bit per level
//   ptr_i   : current lowest-priority level
//   valid_o : at least one request bit set
//   id_o    : winning level (0 when valid_o is 0)
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req_i,
  input  logic [ID_W-1:0]   ptr_i,
  output logic              valid_o,
  output logic [ID_W-1:0]   id_o
);

  logic [ID_W-1:0]     start;
  logic [2*NUM_IR-1:0] req_dbl;
  logic [NUM_IR-1:0]   req_rot;
  logic [ID_W-1:0]     off;

  always_comb begin
    start   = ptr_i + 3'd1;
    // Rotate so bit k of req_rot is level (start + k) mod 8; then a plain
    // lowest-bit-first encode gives the offset from the start level.
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[start +: NUM_IR];
    valid_o = |req_rot;
    off     = '0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = ID_W'(k);
      end
    end
    id_o = valid_o ? (start + off) : '0;
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// Interrupt acknowledge sequencer for the 8-level interrupt controller.
// Owns IRR and ISR, resolves fully nested priority among unmasked requests, raises
// int_out_o and runs the two-pulse INTA handshake, driving the vector during the second
// pulse.
//   clk_i         : system clock
//   reset_n       : synchronous active-low reset, aborts any handshake
//   ir_i          : level-sensitive request lines
//   imr_i         : mask, 1 = level masked
//   vector_base_i : vector bits T7..T3
//   eoi_i         : one-cycle non-specific end-of-interrupt
//   inta_n_i      : CPU acknowledge, active low
//   int_out_o     : interrupt request to CPU
//   data_out_o    : vector to data bus buffer
//   data_oe_o     : buffer drives data_out_o
//   irr_o, isr_o  : current IRR / ISR
// Build option: define PIC_ROTATE_PRIORITY_EN to make each EOI'd level the lowest priority;
// otherwise priority is fixed with IR0 highest.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] ir_i,
  input  logic [NUM_IR-1:0] imr_i,
  input  logic [4:0]        vector_base_i,
  input  logic              eoi_i,
  input  logic              inta_n_i,
  output logic              int_out_o,
  output logic [7:0]        data_out_o,
  output logic              data_oe_o,
  output logic [NUM_IR-1:0] irr_o,
  output logic [NUM_IR-1:0] isr_o
);

  pic_ack_state_t state_q, state_d;

  logic              inta_q;
  logic              int_q, int_d;
  logic [7:0]        data_q, data_d;
  logic              oe_q, oe_d;
  logic [ID_W-1:0]   ack_id_q, ack_id_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;

  logic [ID_W-1:0]   ptr;
  logic              cand_valid;
  logic [ID_W-1:0]   cand_id;
  logic              isr_valid;
  logic [ID_W-1:0]   isr_top;
  logic              req_cond;
  logic              inta_fall;
  logic              inta_rise;

  pic_priority_resolver u_cand (
    .req_i   (irr_q & ~imr_i),
    .ptr_i   (ptr),
    .valid_o (cand_valid),
    .id_o    (cand_id)
  );

  // Same resolver on ISR: gives both the nesting level and the EOI target.
  pic_priority_resolver u_isr (
    .req_i   (isr_q),
    .ptr_i   (ptr),
    .valid_o (isr_valid),
    .id_o    (isr_top)
  );

`ifdef PIC_ROTATE_PRIORITY_EN
  logic [ID_W-1:0] ptr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      ptr_q <= RESET_PTR;
    end else if (eoi_i && isr_valid) begin
      ptr_q <= isr_top;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = RESET_PTR;
`endif

  // Strictly higher than everything in service; equal priority stays blocked.
  assign req_cond  = cand_valid &&
                     (!isr_valid || (prio_rank(cand_id, ptr) < prio_rank(isr_top, ptr)));
  assign inta_fall = inta_q & ~inta_n_i;
  assign inta_rise = ~inta_q & inta_n_i;

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    data_d   = data_q;
    oe_d     = oe_q;
    ack_id_d = ack_id_q;
    irr_d    = ir_i;
    isr_d    = isr_q;

    // EOI works on the pre-edge ISR; a bit set by a coincident first INTA is ORed in below.
    if (eoi_i && isr_valid) begin
      isr_d[isr_top] = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (req_cond) begin
          int_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (inta_fall) begin
          int_d   = 1'b0;
          state_d = StAck1;
          if (req_cond) begin
            ack_id_d       = cand_id;
            isr_d[cand_id] = 1'b1;
            irr_d[cand_id] = 1'b0;
          end else begin
            ack_id_d = SPURIOUS_ID;
          end
        end else if (!req_cond) begin
          // Request withdrawn before the CPU acknowledged it.
          int_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StAck1: begin
        if (inta_rise) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (inta_fall) begin
          data_d  = {vector_base_i, ack_id_q};
          oe_d    = 1'b1;
          state_d = StAck2;
        end
      end
      StAck2: begin
        if (inta_rise) begin
          data_d  = '0;
          oe_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      inta_q   <= 1'b1;
      int_q    <= 1'b0;
      data_q   <= '0;
      oe_q     <= 1'b0;
      ack_id_q <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
    end else begin
      state_q  <= state_d;
      inta_q   <= inta_n_i;
      int_q    <= int_d;
      data_q   <= data_d;
      oe_q     <= oe_d;
      ack_id_q <= ack_id_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
    end
  end

  assign int_out_o  = int_q;
  assign data_out_o = data_q;
  assign data_oe_o  = oe_q;
  assign irr_o      = irr_q;
  assign isr_o      = isr_q;

endmodule
